// File: rtl/pixel_reconstruct.sv
// Camera front stage: detects pixel-clock edges on the synchronised camera bus,
// pairs bytes into RGB565 pixels and tags each one with its column and row.
module pixel_reconstruct #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        camera_pclk_in,
   input  logic        camera_hs_in,
   input  logic        camera_vs_in,
   input  logic [7:0]  camera_data_in,
   output logic        pixel_valid_out,
   output logic [15:0] pixel_data_out,
   output logic [10:0] pixel_hcount_out,
   output logic [9:0]  pixel_vcount_out,
   output logic        frame_start_out,
   output logic        error_out
);

   typedef enum logic [1:0] {SYNC, HBLANK, BYTE_HI, BYTE_LO} state_t;

   localparam logic [31:0] H_LIM = 32'(H_PIXELS);
   localparam logic [31:0] V_LIM = 32'(V_LINES);

   state_t      state_q;
   logic        pclk_prev_q;
   logic        vs_prev_q;
   logic [7:0]  hi_q;
   logic [10:0] col_q;
   logic [9:0]  row_q;
   logic        valid_q;
   logic [15:0] data_q;
   logic [10:0] hcount_q;
   logic [9:0]  vcount_q;
   logic        fs_q;
   logic        err_q;

   logic        edge_w;
   logic        vs_rise_w;
   logic        vs_fall_w;
   logic        in_range_w;
   logic [10:0] col_d;
   logic [9:0]  row_d;

   assign edge_w     = camera_pclk_in & ~pclk_prev_q;
   assign vs_rise_w  = camera_vs_in & ~vs_prev_q;
   assign vs_fall_w  = ~camera_vs_in & vs_prev_q;
   assign in_range_w = (32'(col_q) < H_LIM) && (32'(row_q) < V_LIM);
   assign col_d      = (col_q == '1) ? col_q : col_q + 11'd1;
   assign row_d      = (row_q == '1) ? row_q : row_q + 10'd1;

   // Frame/line state machine with registered pixel, frame-start and error outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= SYNC;
         pclk_prev_q <= 1'b0;
         vs_prev_q   <= 1'b0;
         hi_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         hcount_q    <= '0;
         vcount_q    <= '0;
         fs_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pclk_prev_q <= camera_pclk_in;
         valid_q     <= 1'b0;
         fs_q        <= 1'b0;
         if (edge_w) begin
            vs_prev_q <= camera_vs_in;
            if (state_q == SYNC) begin
               // frame start takes priority over any byte on the same edge
               if (vs_fall_w) begin
                  state_q <= HBLANK;
                  col_q   <= '0;
                  row_q   <= '0;
                  err_q   <= 1'b0;
                  fs_q    <= 1'b1;
               end
            end else if (vs_rise_w) begin
               state_q <= SYNC;
            end else begin
               case (state_q)
                  HBLANK: begin
                     if (camera_hs_in) begin
                        hi_q    <= camera_data_in;
                        state_q <= BYTE_LO;
                     end
                  end
                  BYTE_LO: begin
                     if (camera_hs_in) begin
                        if (in_range_w) begin
                           valid_q  <= 1'b1;
                           data_q   <= {hi_q, camera_data_in};
                           hcount_q <= col_q;
                           vcount_q <= row_q;
                        end else begin
                           err_q <= 1'b1;
                        end
                        col_q   <= col_d;
                        state_q <= BYTE_HI;
                     end else begin
                        err_q   <= 1'b1;
                        col_q   <= '0;
                        row_q   <= row_d;
                        state_q <= HBLANK;
                     end
                  end
                  BYTE_HI: begin
                     if (camera_hs_in) begin
                        hi_q    <= camera_data_in;
                        state_q <= BYTE_LO;
                     end else begin
                        col_q   <= '0;
                        row_q   <= row_d;
                        state_q <= HBLANK;
                     end
                  end
                  default: state_q <= SYNC;
               endcase
            end
         end
      end
   end

   assign pixel_valid_out  = valid_q;
   assign pixel_data_out   = data_q;
   assign pixel_hcount_out = hcount_q;
   assign pixel_vcount_out = vcount_q;
   assign frame_start_out  = fs_q;
   assign error_out        = err_q;

endmodule

// File: tb/tb_pixel_reconstruct.sv
// Bench for pixel_reconstruct: a full-size and a reduced-size instance share one
// camera bus; a byte-counting frame/line model predicts every output cycle.
module tb_pixel_reconstruct;

   logic        clk = 1'b0;
   logic        rst, pclk, hs, vs;
   logic [7:0]  data;

   logic [1:0]  a_valid, a_fs, a_err;
   logic [15:0] a_data [2];
   logic [10:0] a_h [2];
   logic [9:0]  a_v [2];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int n_valid [2];
   int n_fs [2];

   // model state
   int          HP [2] = '{320, 4};
   int          VP [2] = '{240, 2};
   bit          mp;
   bit          inf [2];
   bit          vsp [2];
   int          nb [2];
   int          row [2];
   logic [7:0]  hi [2];
   bit          e_valid [2];
   bit          e_fs [2];
   bit          e_err [2];
   logic [15:0] e_data [2];
   int          e_h [2];
   int          e_v [2];

   always #5 clk = ~clk;

   pixel_reconstruct u_big (
      .clk_in(clk), .rst_in(rst), .camera_pclk_in(pclk), .camera_hs_in(hs),
      .camera_vs_in(vs), .camera_data_in(data),
      .pixel_valid_out(a_valid[0]), .pixel_data_out(a_data[0]),
      .pixel_hcount_out(a_h[0]), .pixel_vcount_out(a_v[0]),
      .frame_start_out(a_fs[0]), .error_out(a_err[0]));

   pixel_reconstruct #(.H_PIXELS(4), .V_LINES(2)) u_small (
      .clk_in(clk), .rst_in(rst), .camera_pclk_in(pclk), .camera_hs_in(hs),
      .camera_vs_in(vs), .camera_data_in(data),
      .pixel_valid_out(a_valid[1]), .pixel_data_out(a_data[1]),
      .pixel_hcount_out(a_h[1]), .pixel_vcount_out(a_v[1]),
      .frame_start_out(a_fs[1]), .error_out(a_err[1]));

   task automatic cmp(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, m, act, exp, $time);
      end
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            cmp("valid", m, 32'(a_valid[m]), 32'(e_valid[m]));
            cmp("frame_start", m, 32'(a_fs[m]), 32'(e_fs[m]));
            cmp("error", m, 32'(a_err[m]), 32'(e_err[m]));
            cmp("data", m, 32'(a_data[m]), 32'(e_data[m]));
            cmp("hcount", m, 32'(a_h[m]), 32'(e_h[m]));
            cmp("vcount", m, 32'(a_v[m]), 32'(e_v[m]));
            if (a_valid[m] === 1'b1) n_valid[m]++;
            if (a_fs[m] === 1'b1) n_fs[m]++;
         end
      end
   end

   // one clk of stimulus; the model predicts what appears after the next posedge
   task automatic step(input logic p, input logic h, input logic v, input logic [7:0] d, input logic r);
      bit ev;
      int c;
      @(negedge clk);
      #1;
      pclk = p; hs = h; vs = v; data = d; rst = r;
      ev = p && !mp;
      mp = r ? 1'b0 : p;
      for (int m = 0; m < 2; m++) begin
         e_valid[m] = 1'b0;
         e_fs[m] = 1'b0;
         if (r) begin
            inf[m] = 0; vsp[m] = 0; nb[m] = 0; row[m] = 0; hi[m] = '0;
            e_err[m] = 0; e_data[m] = '0; e_h[m] = 0; e_v[m] = 0;
         end else if (ev) begin
            if (!inf[m]) begin
               if (vsp[m] && !v) begin
                  inf[m] = 1; row[m] = 0; nb[m] = 0; e_err[m] = 0; e_fs[m] = 1;
               end
            end else if (v && !vsp[m]) begin
               inf[m] = 0;
            end else if (h) begin
               nb[m]++;
               if (nb[m] % 2 == 1) hi[m] = d;
               else begin
                  c = nb[m] / 2 - 1;
                  if (c > 2047) c = 2047;
                  if (c < HP[m] && row[m] < VP[m]) begin
                     e_valid[m] = 1; e_data[m] = {hi[m], d}; e_h[m] = c; e_v[m] = row[m];
                  end else e_err[m] = 1;
               end
            end else if (nb[m] > 0) begin
               if (nb[m] % 2 == 1) e_err[m] = 1;
               if (row[m] < 1023) row[m]++;
               nb[m] = 0;
            end
            vsp[m] = v;
         end
      end
   endtask

   task automatic pedge(input logic h, input logic v, input logic [7:0] d);
      step(1'b1, h, v, d, 1'b0);
      step(1'b0, h, v, d, 1'b0);
   endtask

   task automatic new_frame();
      pedge(1'b0, 1'b1, 8'h00);
      pedge(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_line(input int n, input int b0, input int s);
      for (int i = 0; i < n; i++) pedge(1'b1, 1'b0, 8'(b0 + s * i));
      pedge(1'b0, 1'b0, 8'h00);
   endtask

   task automatic clr();
      for (int m = 0; m < 2; m++) begin
         n_valid[m] = 0;
         n_fs[m] = 0;
      end
   endtask

   initial begin
      rst = 1'b1; pclk = 1'b0; hs = 1'b0; vs = 1'b0; data = '0; mp = 0;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cmp("reset_valid", 0, 32'(a_valid[0]), 32'd0);
      cmp("reset_data", 0, 32'(a_data[0]), 32'd0);

      // 1: first frame, one line A1 B2 C3 D4
      clr();
      new_frame();
      pedge(1'b1, 1'b0, 8'hA1);
      pedge(1'b1, 1'b0, 8'hB2);
      pedge(1'b1, 1'b0, 8'hC3);
      step(1'b1, 1'b1, 1'b0, 8'hD4, 1'b0);
      @(posedge clk); #1;
      cmp("t1_latency_valid", 0, 32'(a_valid[0]), 32'd1);
      cmp("t1_latency_data", 0, 32'(a_data[0]), 32'hC3D4);
      step(1'b0, 1'b1, 1'b0, 8'hD4, 1'b0);
      pedge(1'b0, 1'b0, 8'h00);
      cmp("t1_fs_count", 0, 32'(n_fs[0]), 32'd1);
      cmp("t1_pix_count", 0, 32'(n_valid[0]), 32'd2);
      cmp("t1_hcount", 0, 32'(a_h[0]), 32'd1);
      cmp("t1_error", 0, 32'(a_err[0]), 32'd0);

      // 2: three lines of two pixels, then empty gaps
      new_frame();
      clr();
      for (int l = 0; l < 3; l++) begin
         send_line(4, 16 * l, 1);
         pedge(1'b0, 1'b0, 8'h00);
         cmp("t2_vcount", 0, 32'(a_v[0]), 32'(l));
      end
      cmp("t2_pix_count", 0, 32'(n_valid[0]), 32'd6);
      cmp("t2_small_pix", 1, 32'(n_valid[1]), 32'd4);
      for (int g = 0; g < 4; g++) pedge(1'b0, 1'b0, 8'h00);
      send_line(2, 8'h66, 1);
      cmp("t2_gap_vcount", 0, 32'(a_v[0]), 32'd3);
      cmp("t2_gap_hcount", 0, 32'(a_h[0]), 32'd0);

      // 3: odd byte line
      new_frame();
      clr();
      send_line(3, 8'h20, 1);
      cmp("t3_pix_count", 0, 32'(n_valid[0]), 32'd1);
      cmp("t3_data", 0, 32'(a_data[0]), 32'h2021);
      cmp("t3_error", 0, 32'(a_err[0]), 32'd1);
      send_line(2, 8'h30, 1);
      cmp("t3_next_v", 0, 32'(a_v[0]), 32'd1);
      cmp("t3_next_h", 0, 32'(a_h[0]), 32'd0);
      cmp("t3_error_held", 0, 32'(a_err[0]), 32'd1);
      new_frame();
      cmp("t3_error_clear", 0, 32'(a_err[0]), 32'd0);

      // 4: H and V limits on the small instance
      clr();
      send_line(12, 8'h40, 1);
      cmp("t4_small_pix", 1, 32'(n_valid[1]), 32'd4);
      cmp("t4_small_h", 1, 32'(a_h[1]), 32'd3);
      cmp("t4_small_err", 1, 32'(a_err[1]), 32'd1);
      cmp("t4_big_pix", 0, 32'(n_valid[0]), 32'd6);
      send_line(2, 8'h50, 1);
      clr();
      send_line(2, 8'h52, 1);
      cmp("t4_small_vlimit", 1, 32'(n_valid[1]), 32'd0);
      cmp("t4_big_third", 0, 32'(n_valid[0]), 32'd1);

      // 5: vs rises mid-pixel, then falls together with hs=1
      clr();
      pedge(1'b1, 1'b0, 8'h55);
      pedge(1'b0, 1'b1, 8'h00);
      cmp("t5_no_strobe", 0, 32'(n_valid[0]), 32'd0);
      pedge(1'b1, 1'b0, 8'h77);
      send_line(2, 8'h11, 8'h11);
      cmp("t5_fs", 0, 32'(n_fs[0]), 32'd1);
      cmp("t5_data", 0, 32'(a_data[0]), 32'h1122);
      cmp("t5_pos", 0, 32'({a_h[0], a_v[0]}), 32'd0);

      // 6: one-clk reset in the middle of a line
      pedge(1'b1, 1'b0, 8'hAA);
      clr();
      step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1);
      pedge(1'b1, 1'b0, 8'hBB);
      pedge(1'b1, 1'b0, 8'hCC);
      pedge(1'b1, 1'b0, 8'hDD);
      pedge(1'b0, 1'b0, 8'h00);
      cmp("t6_no_pix", 0, 32'(n_valid[0]), 32'd0);
      cmp("t6_no_fs", 0, 32'(n_fs[0]), 32'd0);
      new_frame();
      send_line(2, 8'h12, 8'h22);
      cmp("t6_fs", 0, 32'(n_fs[0]), 32'd1);
      cmp("t6_data", 0, 32'(a_data[0]), 32'h1234);

      pedge(1'b0, 1'b0, 8'h00);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
